// File: rtl/mul_chk_pkg.sv
// Shared types and helpers for the approximate-multiplier sweep checker.
package mul_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/mul_err_stage.sv
// Second pipeline stage: exact product, absolute error against the approximate
// result, and running worst-case / violation statistics.
module mul_err_stage
  import mul_chk_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int OUT_W = 4,
  parameter int ET    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             valid,
  input  logic [IN_W-1:0]  vec,
  input  logic [OUT_W-1:0] approx,
  output logic [OUT_W:0]   max_err,
  output logic [IN_W:0]    viol_cnt,
  output logic [IN_W-1:0]  first_viol_vec
);

  localparam int HW = IN_W / 2;

  logic [HW-1:0]      op_a;
  logic [IN_W-HW-1:0] op_b;
  logic [OUT_W-1:0]   exact;
  logic [OUT_W:0]     err;
  logic               viol;
  logic               seen_viol;

  // Product is formed directly at OUT_W bits so truncation matches the netlist width.
  always_comb begin
    op_a  = vec[HW-1:0];
    op_b  = vec[IN_W-1:HW];
    exact = OUT_W'(op_a) * OUT_W'(op_b);
    err   = (OUT_W+1)'(abs_diff(32'(exact), 32'(approx)));
    viol  = 32'(err) > 32'(ET);
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      max_err        <= '0;
      viol_cnt       <= '0;
      first_viol_vec <= '0;
      seen_viol      <= 1'b0;
    end else if (valid) begin
      if (err > max_err) max_err <= err;
      if (viol) begin
        viol_cnt <= viol_cnt + 1'b1;
        if (!seen_viol) begin
          first_viol_vec <= vec;
          seen_viol      <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mul_sweep_err_checker.sv
// Exhaustive sweep checker: drives every input vector into an external approximate
// multiplier and reports worst-case error and threshold violations.
module mul_sweep_err_checker
  import mul_chk_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int OUT_W = 4,
  parameter int ET    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ack,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [OUT_W:0]   max_err,
  output logic [IN_W:0]    viol_cnt,
  output logic [IN_W-1:0]  first_viol_vec,
  output state_t           dbg_state
);

  // Handshake: start is a one-cycle request honoured only in IDLE; ack is a
  // one-cycle release honoured only in DONE. Both are ignored in every other state.

  state_t           state, state_nxt;
  logic [IN_W:0]    cnt;
  logic             drain_cnt;
  logic             sweep_go;
  logic             issuing;
  logic             drain_last;
  logic [IN_W-1:0]  s1_vec;
  logic [OUT_W-1:0] s1_out;
  logic             s1_valid;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)     state_nxt = SWEEP;
      SWEEP:   if (cnt[IN_W]) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt) state_nxt = DONE;
      DONE:    if (ack)       state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state == SWEEP) || (state == DRAIN);
    done       = (state == DONE);
    dbg_state  = state;
    sweep_go   = (state == IDLE) && start;
    issuing    = (state == SWEEP) && !cnt[IN_W];
    drain_last = (state == DRAIN) && drain_cnt;
  end

  // cnt carries one extra bit so the sweep ends without dut_in wrapping to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      dut_in    <= '0;
      drain_cnt <= 1'b0;
      s1_valid  <= 1'b0;
      s1_vec    <= '0;
      s1_out    <= '0;
      pass      <= 1'b0;
    end else begin
      s1_valid  <= issuing;
      s1_vec    <= dut_in;
      s1_out    <= dut_out;
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
      if (sweep_go) begin
        cnt    <= '0;
        dut_in <= '0;
        pass   <= 1'b0;
      end else if (issuing) begin
        cnt <= cnt + 1'b1;
        if (dut_in != '1) dut_in <= dut_in + 1'b1;
      end
      if (drain_last) pass <= (viol_cnt == '0);
    end
  end

  mul_err_stage #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .ET    (ET)
  ) u_err_stage (
    .clk            (clk),
    .rst            (rst),
    .clr            (sweep_go),
    .valid          (s1_valid),
    .vec            (s1_vec),
    .approx         (s1_out),
    .max_err        (max_err),
    .viol_cnt       (viol_cnt),
    .first_viol_vec (first_viol_vec)
  );

endmodule

// File: tb/tb_mul_sweep_err_checker.sv
// Bench for mul_sweep_err_checker: lookup-table approximate netlist, per-cycle
// behavioural model of the sweep, directed cases and randomized sweeps.
module tb_mul_sweep_err_checker;
  import mul_chk_pkg::*;

  localparam int P_FRESH = 0;
  localparam int P_IDLE  = 1;
  localparam int P_RUN   = 2;
  localparam int P_DONE  = 3;

  logic       clk = 1'b0;
  logic       rst, start, ack;
  logic [3:0] dut_in, dut_out;
  logic       busy, done, pass;
  logic [4:0] max_err, viol_cnt;
  logic [3:0] first_viol_vec;
  state_t     dbg_state;

  logic [3:0] lut [16];
  int checks = 0;
  int failures = 0;

  int ph = P_FRESH;
  int k = 0;
  bit model_valid = 0;
  int exp_max, exp_viol, exp_first;

  // clock / reset
  always #5 clk = ~clk;

  always_comb dut_out = lut[dut_in];

  mul_sweep_err_checker #(.IN_W(4), .OUT_W(4), .ET(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .ack            (ack),
    .dut_in         (dut_in),
    .dut_out        (dut_out),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .max_err        (max_err),
    .viol_cnt       (viol_cnt),
    .first_viol_vec (first_viol_vec),
    .dbg_state      (dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected statistics straight from the definition over the whole input space.
  function automatic void calc_expect();
    int a, b, exact, e;
    bit seen;
    exp_max = 0; exp_viol = 0; exp_first = 0; seen = 0;
    for (int v = 0; v < 16; v++) begin
      a = v % 4;
      b = v / 4;
      exact = (a * b) % 16;
      e = (exact > int'(lut[v])) ? exact - int'(lut[v]) : int'(lut[v]) - exact;
      if (e > exp_max) exp_max = e;
      if (e > 8) begin
        exp_viol++;
        if (!seen) exp_first = v;
        seen = 1;
      end
    end
  endfunction

  // Model: k counts edges since the start-sampling edge; done is due at k == 19.
  always @(posedge clk) begin
    if (rst) begin
      ph = P_FRESH;
      k = 0;
      model_valid = 1;
    end else begin
      case (ph)
        P_FRESH, P_IDLE: if (start) begin ph = P_RUN; k = 0; end
        P_RUN: begin
          k++;
          if (k == 19) begin
            ph = P_DONE;
            calc_expect();
          end
        end
        P_DONE: if (ack) ph = P_IDLE;
        default: ph = P_FRESH;
      endcase
    end
  end

  // scoreboard compare, every cycle
  always @(negedge clk) begin
    if (model_valid) begin
      check("busy", busy, (ph == P_RUN));
      check("done", done, (ph == P_DONE));
      if (ph == P_RUN) check("dut_in", dut_in, (k < 15) ? k : 15);
      if (ph == P_FRESH) begin
        check("rst_dut_in", dut_in, 0);
        check("rst_max_err", max_err, 0);
        check("rst_viol_cnt", viol_cnt, 0);
        check("rst_first", first_viol_vec, 0);
        check("rst_pass", pass, 0);
      end
      if (ph == P_DONE || ph == P_IDLE) begin
        check("max_err", max_err, exp_max);
        check("viol_cnt", viol_cnt, exp_viol);
        check("first_viol_vec", first_viol_vec, exp_first);
      end
      if (ph == P_DONE) check("pass", pass, (exp_viol == 0));
    end
  end

  // driver tasks
  task automatic set_lut(input int mode);
    for (int v = 0; v < 16; v++) begin
      case (mode)
        0: lut[v] = 4'((v % 4) * (v / 4));
        1: lut[v] = 4'h0;
        2: lut[v] = 4'hF;
        4: lut[v] = (v == 15) ? 4'h1 : 4'((v % 4) * (v / 4));
        default: lut[v] = 4'($urandom_range(0, 15));
      endcase
    end
  endtask

  task automatic run_sweep(input bit restart, input bit rst_mid, input bit stray_ack, output int n);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      start = restart && (n == 5);
      ack   = stray_ack && (n == 3);
      if (rst_mid && n == 8) begin
        start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_dut_in", dut_in, 0);
        check("abort_viol_cnt", viol_cnt, 0);
        return;
      end
    end
    start = 1'b0;
    ack = 1'b0;
    check("done_seen", done, 1);
  endtask

  task automatic do_ack(input int delay);
    repeat (delay) @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("ack_done_low", done, 0);
  endtask

  task automatic pin_results(input string tag, input int mx, input int vc, input int fv, input int ps);
    check({tag, "_max_err"}, max_err, mx);
    check({tag, "_viol_cnt"}, viol_cnt, vc);
    check({tag, "_first"}, first_viol_vec, fv);
    check({tag, "_pass"}, pass, ps);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; ack = 1'b0;
    set_lut(0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    set_lut(0);
    run_sweep(0, 0, 0, n);
    check("latency_exact", n, 19);
    pin_results("exact", 0, 0, 0, 1);
    do_ack(1);

    set_lut(1);
    run_sweep(0, 0, 0, n);
    pin_results("zero", 9, 1, 15, 0);
    do_ack(0);

    set_lut(2);
    run_sweep(0, 0, 0, n);
    pin_results("allf", 15, 15, 0, 0);
    do_ack(2);

    set_lut(0);
    run_sweep(1, 0, 1, n);
    check("latency_restart", n, 19);
    pin_results("restart", 0, 0, 0, 1);
    do_ack(0);

    set_lut(4);
    run_sweep(0, 0, 0, n);
    pin_results("edge_et", 8, 0, 0, 1);
    do_ack(0);

    set_lut(1);
    run_sweep(0, 1, 0, n);
    @(negedge clk);
    run_sweep(0, 0, 0, n);
    check("latency_after_rst", n, 19);
    pin_results("after_rst", 9, 1, 15, 0);

    repeat (20) @(negedge clk);
    pin_results("hold", 9, 1, 15, 0);
    do_ack(0);
    check("idle_keep_max", max_err, 9);
    check("idle_keep_viol", viol_cnt, 1);
    check("idle_keep_first", first_viol_vec, 15);

    for (int i = 0; i < 10; i++) begin
      set_lut(3);
      repeat ($urandom_range(0, 4)) @(negedge clk);
      run_sweep(1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)), n);
      check("latency_rand", n, 19);
      do_ack($urandom_range(0, 5));
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
